lsu_mem_port: RTL

Load/store initiator that drives the single-port `data_mem` on behalf of the core. It accepts one load or store request at a time over a valid/ready handshake and converts LB/LH/LW/LBU/LHU/SB/SH/SW semantics into word-aligned, byte-lane-masked accesses. It returns sign- or zero-extended load data and sits between the execute stage and `data_mem`.

---
 rtl/lsu_mem_port_if.sv | 39 +++
 rtl/lsu_mem_port.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port_if.sv
// Load/store request/response and data_mem bus bundle for lsu_mem_port.
//   req_*   : single-request valid/ready handshake from the execute stage
//   resp_*  : one-cycle response pulse with extended load data
//   mem_*   : word-aligned, byte-lane-masked port to data_mem
// Modports: slave = lsu_mem_port side, master = requester/memory side.
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic [3:0]        mem_wr_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misaligned,
        output mem_wr_sel, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misaligned,
        input  mem_wr_sel, mem_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator driving the single-port data_mem.
// Ports:
//   clk   : system clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : lsu_mem_port_if.slave (request, response and data_mem signals)
// Build option: define LSU_MISALIGNED_SPLIT_EN to split word-crossing
// accesses into two word accesses; otherwise they perform no memory access
// and respond with resp_misaligned=1, resp_rdata=0.
//
// state  | meaning
// IDLE   | ready for a request, latch it on req_valid
// ACCESS | first (or only) word access
// SECOND | upper word of a split access
// RESP   | one-cycle response pulse
module lsu_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_mem_port_if.slave bus
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, SECOND, RESP} state_t;

    state_t            state, state_nxt;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       lo_data;
    logic [31:0]       hi_data;

    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic [7:0]        lane_mask8;
    logic [63:0]       wdata64;
    logic              crosses;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] word_addr_hi;
    logic [63:0]       ld_cat;
    logic [31:0]       ld_sh;
    logic [31:0]       ld_ext;
    logic [3:0]        wr_sel_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            lo_data <= 32'd0;
            hi_data <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (state == ACCESS) lo_data <= bus.mem_rd_data;
            if (state == SECOND) hi_data <= bus.mem_rd_data;
        end
    end

    // Lane mask and store data are built 8 lanes / 64 bits wide so that the
    // upper half directly gives the lanes and data of the second word.
    always_comb begin
        off = r_addr[1:0];
        case (r_size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask8   = {4'b0000, size_mask} << off;
        wdata64      = {32'd0, r_wdata} << {off, 3'b000};
        crosses      = |lane_mask8[7:4];
        word_addr    = {r_addr[ADDR_W-1:2], 2'b00};
        word_addr_hi = word_addr + ADDR_W'(4);
        ld_cat       = {hi_data, lo_data};
        ld_sh        = 32'(ld_cat >> {off, 3'b000});
        if (r_size[1])
            ld_ext = ld_sh;
        else if (r_size[0])
            ld_ext = r_uns ? {16'd0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
        else
            ld_ext = r_uns ? {24'd0, ld_sh[7:0]} : {{24{ld_sh[7]}}, ld_sh[7:0]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = (crosses && SPLIT_EN) ? SECOND : RESP;
            SECOND:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready       = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.resp_rdata      = 32'd0;
        bus.resp_misaligned = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_wr_data     = 32'd0;
        wr_sel_raw          = 4'b0000;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            ACCESS: begin
                bus.mem_addr = word_addr;
                // Unsplit misaligned stores must not touch memory.
                if (r_we && (!crosses || SPLIT_EN)) begin
                    wr_sel_raw      = lane_mask8[3:0];
                    bus.mem_wr_data = wdata64[31:0];
                end
            end
            SECOND: begin
                bus.mem_addr = word_addr_hi;
                if (r_we) begin
                    wr_sel_raw      = lane_mask8[7:4];
                    bus.mem_wr_data = wdata64[63:32];
                end
            end
            RESP: begin
                bus.resp_valid      = 1'b1;
                bus.resp_misaligned = crosses;
                if (!r_we && !(crosses && !SPLIT_EN))
                    bus.resp_rdata = ld_ext;
            end
            default: ;
        endcase
    end

    // Gate with rst_n so a write can never commit in a reset cycle.
    assign bus.mem_wr_sel = wr_sel_raw & {4{rst_n}};

endmodule
